// File: rtl/vid_pkg.sv
// Shared defaults, widths and FSM encoding for the vertex-ID bank packer.
package vid_pkg;
    localparam int K_DEF       = 16;
    localparam int Q_DEF       = 16;
    localparam int VID_BW_DEF  = 16;
    localparam int ADDR_BW_DEF = 8;
    localparam int NEXT_BW     = $clog2(K_DEF);
    localparam int CNT_BW      = $clog2(2 * Q_DEF);
    localparam logic [VID_BW_DEF-1:0] FILL = '1;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;
endpackage

// File: rtl/vid_bank_buf.sv
// One bank's staging buffer: packs hit lanes, emits full lines or padded flush lines,
// and tracks the bank's line address and full flag.
module vid_bank_buf #(
    parameter int Q       = 16,
    parameter int VID_BW  = 16,
    parameter int ADDR_BW = 8,
    parameter logic [VID_BW-1:0] FILL = '1,
    localparam int CNT_BW = $clog2(2 * Q)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [Q-1:0]                hit,
    input  logic [Q-1:0][VID_BW-1:0]    vid,
    input  logic                        flush_now,
    output logic                        wen_q,
    output logic [Q*VID_BW-1:0]         wdata_q,
    output logic [ADDR_BW-1:0]          waddr_q,
    output logic                        ovf
);
    logic [2*Q-2:0][VID_BW-1:0] slots_q, slots_d;
    logic [2*Q-1:0][VID_BW-1:0] ext;
    logic [CNT_BW-1:0]          cnt_q, cnt_d, pos;
    logic [ADDR_BW-1:0]         addr_q, addr_d, waddr_d;
    logic                       full_q, full_d, wen_d, wr;
    logic [Q*VID_BW-1:0]        wdata_d;

    always_comb begin
        // Spare top slot lets the packing loop index without a bound check.
        ext     = {{VID_BW{1'b0}}, slots_q};
        pos     = cnt_q;
        for (int i = 0; i < Q; i++) begin
            if (hit[i]) begin
                ext[pos] = vid[i];
                pos      = pos + 1'b1;
            end
        end
        slots_d = slots_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        waddr_d = waddr_q;
        addr_d  = addr_q;
        full_d  = full_q;
        wen_d   = 1'b0;
        wr      = 1'b0;
        ovf     = 1'b0;
        if (flush_now) begin
            cnt_d = '0;
            if (cnt_q != '0) begin
                wr = 1'b1;
                for (int s = 0; s < Q; s++)
                    wdata_d[(Q-1-s)*VID_BW +: VID_BW] = (CNT_BW'(s) < cnt_q) ? slots_q[s] : FILL;
            end
        end else begin
            slots_d = ext[2*Q-2:0];
            cnt_d   = pos;
            if (pos >= CNT_BW'(Q)) begin
                wr = 1'b1;
                for (int s = 0; s < Q; s++)
                    wdata_d[(Q-1-s)*VID_BW +: VID_BW] = ext[s];
                for (int j = 0; j < Q - 1; j++)
                    slots_d[j] = ext[j+Q];
                cnt_d = pos - CNT_BW'(Q);
            end
        end
        if (wr) begin
            wen_d   = 1'b1;
            waddr_d = addr_q;
            addr_d  = addr_q + 1'b1;
            ovf     = full_q;
            if (&addr_q) full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slots_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            full_q  <= 1'b0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            waddr_q <= '0;
        end else begin
            slots_q <= slots_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            full_q  <= full_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            waddr_q <= waddr_d;
        end
    end
endmodule

// File: rtl/vid_bank_packer.sv
// Vertex-ID write packer: routes accepted lanes to per-bank buffers and sequences
// run / flush / done, with epoch counting and sticky overflow.
module vid_bank_packer
    import vid_pkg::*;
#(
    parameter int K       = K_DEF,
    parameter int Q       = Q_DEF,
    parameter int VID_BW  = VID_BW_DEF,
    parameter int ADDR_BW = ADDR_BW_DEF,
    parameter logic [VID_BW-1:0] FILL = '1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [Q*VID_BW-1:0]     in_vid,
    input  logic [Q*$clog2(K)-1:0]  in_dest,
    input  logic [Q-1:0]            in_accept,
    input  logic                    flush,
    output logic [K-1:0]            vidsram_wen,
    output logic [K*Q*VID_BW-1:0]   vidsram_wdata,
    output logic [K*ADDR_BW-1:0]    vidsram_waddr,
    output logic [15:0]             epoch,
    output logic                    overflow,
    output logic                    finish
);
    localparam int NB = $clog2(K);

    state_e                     state_q, state_d;
    logic [15:0]                epoch_q, epoch_d;
    logic                       overflow_q, overflow_d, finish_q, finish_d;
    logic                       accept, flush_now;
    logic [Q-1:0][VID_BW-1:0]   lane_vid;
    logic [K-1:0]               ovf_b;

    assign in_ready  = (state_q == RUN) && enable;
    assign accept    = in_valid && in_ready;
    assign flush_now = (state_q == FLUSH);

    for (genvar i = 0; i < Q; i++) begin : g_lane
        assign lane_vid[i] = in_vid[(Q-1-i)*VID_BW +: VID_BW];
    end

    for (genvar b = 0; b < K; b++) begin : g_bank
        logic [Q-1:0] hit;
        for (genvar i = 0; i < Q; i++) begin : g_hit
            assign hit[i] = accept && in_accept[Q-1-i] && (in_dest[(Q-1-i)*NB +: NB] == NB'(b));
        end
        vid_bank_buf #(.Q(Q), .VID_BW(VID_BW), .ADDR_BW(ADDR_BW), .FILL(FILL)) u_buf (
            .clk      (clk),
            .rst      (rst),
            .hit      (hit),
            .vid      (lane_vid),
            .flush_now(flush_now),
            .wen_q    (vidsram_wen[K-1-b]),
            .wdata_q  (vidsram_wdata[(K-1-b)*Q*VID_BW +: Q*VID_BW]),
            .waddr_q  (vidsram_waddr[(K-1-b)*ADDR_BW +: ADDR_BW]),
            .ovf      (ovf_b[b])
        );
    end

    always_comb begin
        state_d    = state_q;
        epoch_d    = epoch_q + (accept ? 16'd1 : 16'd0);
        finish_d   = finish_q;
        overflow_d = overflow_q | (|ovf_b);
        case (state_q)
            IDLE:    if (enable) state_d = RUN;
            RUN:     if (flush) state_d = FLUSH;
            FLUSH: begin
                state_d  = DONE;
                finish_d = 1'b1;
            end
            default: state_d = DONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            epoch_q    <= '0;
            overflow_q <= 1'b0;
            finish_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            epoch_q    <= epoch_d;
            overflow_q <= overflow_d;
            finish_q   <= finish_d;
        end
    end

    assign epoch    = epoch_q;
    assign overflow = overflow_q;
    assign finish   = finish_q;
endmodule
